game_ctrl: RTL

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/game_ctrl.sv
// ---------------------------------------------------------------------------
// game_ctrl
// Top-level game sequencer for the side-scroller. It takes the two raw
// buttons and the per-frame collision/score information and runs the
// attract / play / hit / game-over flow. It also drives the scroller's
// enable and reset, the life counter, the difficulty level and the
// player-sprite blink.
//
// Ports
//   clk         : system clock
//   reset       : synchronous active-high reset
//   btn_start   : raw asynchronous start button
//   btn_move    : raw asynchronous move button
//   frame_tick  : one-cycle pulse per video frame
//   collision   : player/obstacle overlap level
//   score       : current score from the scroller (0..99)
//   scroll_en   : scroller move enable (registered)
//   scroll_rst  : scroller reset (registered)
//   state       : FSM state code, ATTRACT=0 PLAY=1 HIT=2 OVER=3 (registered)
//   lives       : remaining lives (registered)
//   speed_level : difficulty level 0..3 (registered)
//   blink       : player sprite visibility (registered)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// game_ctrl_debounce
// Two-flop synchronizer followed by a stability counter for one button.
//
// Ports
//   clk, reset : as in the top level
//   raw        : asynchronous button input
//   level      : debounced button level
// ---------------------------------------------------------------------------
module game_ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] stable_cnt;

  // The synchronized sample is compared against the accepted level. The
  // counter measures how many consecutive samples in a row have held the
  // other value. Any sample that matches the accepted level again restarts
  // the count, so a bouncing contact never gets through. The new level is
  // taken on the DEBOUNCE_CYCLES-th differing sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      stable_cnt <= '0;
      level      <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level      <= sync2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

module game_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LIVES_INIT      = 3,
  parameter int HIT_FRAMES      = 60,
  parameter int LEVEL_STEP      = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_move,
  input  logic       frame_tick,
  input  logic       collision,
  input  logic [6:0] score,
  output logic       scroll_en,
  output logic       scroll_rst,
  output logic [1:0] state,
  output logic [1:0] lives,
  output logic [1:0] speed_level,
  output logic       blink
);

  // The frame counter is kept at least 3 bits wide so that the
  // "every 8th tick" blink test can always look at the low three bits.
  localparam int FW_RAW = $clog2(HIT_FRAMES + 1);
  localparam int FW     = (FW_RAW < 3) ? 3 : FW_RAW;

  typedef enum logic [1:0] {
    ATTRACT = 2'd0,
    PLAY    = 2'd1,
    HIT     = 2'd2,
    OVER    = 2'd3
  } state_t;

  logic          start_db;
  logic          start_db_d;
  logic          start_pulse;
  logic          move_db;

  state_t        state_q, state_d;
  logic [1:0]    lives_q, lives_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [FW-1:0] frame_inc;
  logic          blink_q, blink_d;
  logic          scroll_en_q, scroll_en_d;
  logic          scroll_rst_q, scroll_rst_d;
  logic [1:0]    speed_q, speed_d;
  logic [1:0]    speed_raw;
  logic [31:0]   score_w;

  game_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_start),
    .level (start_db)
  );

  game_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_move (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_move),
    .level (move_db)
  );

  // Remember the previous debounced start level so that a held button
  // produces a single rising-edge pulse rather than repeated starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_db_d <= 1'b0;
    end else begin
      start_db_d <= start_db;
    end
  end

  assign start_pulse = start_db & ~start_db_d;
  assign score_w     = {25'd0, score};
  assign frame_inc   = frame_cnt_q + 1'b1;

  // Difficulty follows the score thresholds directly. It is masked to 0
  // later when the game is not running.
  always_comb begin
    speed_raw = 2'd3;
    if (score_w < 32'(LEVEL_STEP)) begin
      speed_raw = 2'd0;
    end else if (score_w < 32'(2 * LEVEL_STEP)) begin
      speed_raw = 2'd1;
    end else if (score_w < 32'(3 * LEVEL_STEP)) begin
      speed_raw = 2'd2;
    end
  end

  // Next-state logic. All outputs are registered from the *next* state, so
  // the outputs always line up with the state code in the same cycle. This
  // is what keeps scroll_en low on the very first cycle after leaving PLAY.
  // A collision is checked before the win condition, so a hit on the
  // winning frame still costs a life.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      ATTRACT: begin
        if (start_pulse) begin
          state_d = PLAY;
          lives_d = 2'(LIVES_INIT);
        end
      end
      PLAY: begin
        if (collision) begin
          if (lives_q <= 2'd1) begin
            lives_d = 2'd0;
            state_d = OVER;
          end else begin
            lives_d     = lives_q - 2'd1;
            state_d     = HIT;
            frame_cnt_d = '0;
          end
        end else if (score_w >= 32'd99) begin
          state_d = OVER;
        end
      end
      HIT: begin
        if (frame_tick) begin
          if (frame_inc == FW'(HIT_FRAMES)) begin
            state_d     = PLAY;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_inc;
          end
        end
      end
      OVER: begin
        if (start_pulse) begin
          state_d = ATTRACT;
        end
      end
      default: begin
        state_d = ATTRACT;
      end
    endcase
  end

  // Output decode, based on the state being entered. While HIT runs, the
  // sprite starts hidden and flips on every 8th frame tick. That gives a
  // slow flash while the player is invulnerable.
  always_comb begin
    blink_d      = 1'b0;
    scroll_en_d  = 1'b0;
    scroll_rst_d = 1'b0;
    speed_d      = 2'd0;

    case (state_d)
      ATTRACT: begin
        scroll_rst_d = 1'b1;
      end
      PLAY: begin
        blink_d     = 1'b1;
        scroll_en_d = move_db;
        speed_d     = speed_raw;
      end
      HIT: begin
        speed_d = speed_raw;
        if (state_q != HIT) begin
          blink_d = 1'b0;
        end else if (frame_tick && (frame_inc[2:0] == 3'd0)) begin
          blink_d = ~blink_q;
        end else begin
          blink_d = blink_q;
        end
      end
      default: begin
        blink_d = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset returns the game to ATTRACT with the
  // scroller held in reset. It also throws away any partial HIT count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ATTRACT;
      lives_q      <= 2'd0;
      frame_cnt_q  <= '0;
      blink_q      <= 1'b0;
      scroll_en_q  <= 1'b0;
      scroll_rst_q <= 1'b1;
      speed_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      frame_cnt_q  <= frame_cnt_d;
      blink_q      <= blink_d;
      scroll_en_q  <= scroll_en_d;
      scroll_rst_q <= scroll_rst_d;
      speed_q      <= speed_d;
    end
  end

  assign state       = state_q;
  assign lives       = lives_q;
  assign blink       = blink_q;
  assign scroll_en   = scroll_en_q;
  assign scroll_rst  = scroll_rst_q;
  assign speed_level = speed_q;

endmodule
